// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 pixel timing (DrawX/DrawY/blank) with hs/vs delayed
//               SYNC_DELAY cycles to line up with registered mapper RGB.
//               Optional frame strobe/counter under macro VGA_FRAME_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_count
`endif
);

  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else begin
      hc <= h_wrap ? 10'd0 : hc + 10'd1;
      if (h_wrap) begin
        vc <= v_wrap ? 10'd0 : vc + 10'd1;
      end
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = (hc < H_VIS_END) && (vc < V_VIS_END);
  assign hs_raw = !((hc >= H_SYNC_BEG) && (hc <= H_SYNC_END));
  assign vs_raw = !((vc >= V_SYNC_BEG) && (vc <= V_SYNC_END));

  // Sync stages reset to the inactive (high) level so no spurious pulse
  // appears while the pipeline refills after reset.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_comb
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else if (SYNC_DELAY == 1) begin : g_sync_one
      logic hs_q;
      logic vs_q;
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_q <= 1'b1;
          vs_q <= 1'b1;
        end else begin
          hs_q <= hs_raw;
          vs_q <= vs_raw;
        end
      end
      assign hs = hs_q;
      assign vs = vs_q;
    end else begin : g_sync_multi
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_sr <= '1;
          vs_sr <= '1;
        end else begin
          hs_sr <= {hs_sr[SYNC_DELAY-2:0], hs_raw};
          vs_sr <= {vs_sr[SYNC_DELAY-2:0], vs_raw};
        end
      end
      assign hs = hs_sr[SYNC_DELAY-1];
      assign vs = vs_sr[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  assign frame_start = (hc == 10'd0) && (vc == 10'd0);

  // Counts on the last-pixel wrap so the new value coincides with frame_start.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench: full-size DUT for line timing, two
//               reduced-geometry DUTs (SYNC_DELAY 0 and 3) for frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic       clk;
  logic       reset;

  logic [9:0] d_x, d_y;
  logic       d_blank, d_hs, d_vs;
  logic [9:0] z_x, z_y;
  logic       z_blank, z_hs, z_vs;
  logic [9:0] t_x, t_y;
  logic       t_blank, t_hs, t_vs;
`ifdef VGA_FRAME_CNT_EN
  logic        d_fs, z_fs, t_fs;
  logic [15:0] d_fc, z_fc, t_fc;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .reset(reset), .DrawX(d_x), .DrawY(d_y),
    .blank(d_blank), .hs(d_hs), .vs(d_vs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(d_fs), .frame_count(d_fc)
`endif
  );

  // Reduced geometry: line = 16 cycles, frame = 13 lines = 208 cycles.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)
  ) dut_z (
    .vga_clk(clk), .reset(reset), .DrawX(z_x), .DrawY(z_y),
    .blank(z_blank), .hs(z_hs), .vs(z_vs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(z_fs), .frame_count(z_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(3)
  ) dut_t (
    .vga_clk(clk), .reset(reset), .DrawX(t_x), .DrawY(t_y),
    .blank(t_blank), .hs(t_hs), .vs(t_vs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_start(t_fs), .frame_count(t_fc)
`endif
  );

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[12];
  vec_t sb_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int k, input int x, input int y,
                              input bit b, input bit h, input bit v);
    vec_t r;
    r.k = k; r.x = 10'(x); r.y = 10'(y); r.blank = b; r.hs = h; r.vs = v;
    return r;
  endfunction

  int hs_low, hs_first;
  int zvs_low, zvs_first, zvs_last, tvs_low, tvs_first, tvs_last;
  int zhs_low, zhs_first, ths_low, ths_first;
  int blank_bad;
  int fs_pulses;
  vec_t e;

  initial begin
    // k = cycles since reset release; expected values for the 640x480 DUT
    vecs[0]  = mk(0,    0,   0, 1, 1, 1);
    vecs[1]  = mk(1,    1,   0, 1, 1, 1);
    vecs[2]  = mk(639,  639, 0, 1, 1, 1);
    vecs[3]  = mk(640,  640, 0, 0, 1, 1);
    vecs[4]  = mk(657,  657, 0, 0, 1, 1);
    vecs[5]  = mk(658,  658, 0, 0, 0, 1);
    vecs[6]  = mk(753,  753, 0, 0, 0, 1);
    vecs[7]  = mk(754,  754, 0, 0, 1, 1);
    vecs[8]  = mk(799,  799, 0, 0, 1, 1);
    vecs[9]  = mk(800,  0,   1, 1, 1, 1);
    vecs[10] = mk(1439, 639, 1, 1, 1, 1);
    vecs[11] = mk(1440, 640, 1, 0, 1, 1);

    hs_low = 0; hs_first = -1;
    zvs_low = 0; zvs_first = -1; zvs_last = -1;
    tvs_low = 0; tvs_first = -1; tvs_last = -1;
    zhs_low = 0; zhs_first = -1; ths_low = 0; ths_first = -1;
    blank_bad = 0; fs_pulses = 0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (vecs[i]) sb_q.push_back(vecs[i]);

    for (int k = 0; k <= 1700; k++) begin
      if (k > 0) step();

      if (sb_q.size() > 0 && sb_q[0].k == k) begin
        e = sb_q.pop_front();
        chk($sformatf("DrawX@k%0d", k), int'(d_x), int'(e.x));
        chk($sformatf("DrawY@k%0d", k), int'(d_y), int'(e.y));
        chk($sformatf("blank@k%0d", k), int'(d_blank), int'(e.blank));
        chk($sformatf("hs@k%0d", k), int'(d_hs), int'(e.hs));
        chk($sformatf("vs@k%0d", k), int'(d_vs), int'(e.vs));
      end

      if (k < 800 && !d_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end

      if (k < 208) begin
        if (!z_vs) begin zvs_low++; if (zvs_first < 0) zvs_first = k; zvs_last = k; end
        if (!t_vs) begin tvs_low++; if (tvs_first < 0) tvs_first = k; tvs_last = k; end
        if ((z_y >= 10'd6 && z_blank) || (t_y >= 10'd6 && t_blank)) blank_bad++;
        if (k < 16) begin
          if (!z_hs) begin zhs_low++; if (zhs_first < 0) zhs_first = k; end
          if (!t_hs) begin ths_low++; if (ths_first < 0) ths_first = k; end
        end
      end

      if (k == 208) begin
        chk("small_frame_wrap_x", int'(z_x) + int'(t_x), 0);
        chk("small_frame_wrap_y", int'(z_y) + int'(t_y), 0);
      end

`ifdef VGA_FRAME_CNT_EN
      if (k <= 416 && t_fs) fs_pulses++;
      if (k == 0 || k == 208 || k == 416) begin
        chk($sformatf("frame_start@k%0d", k), int'(t_fs), 1);
        chk($sformatf("frame_count@k%0d", k), int'(t_fc), k / 208);
      end
      if (k == 0) chk("frame_count_reset_full", int'(d_fc), 0);
      if (k == 300) dut_z.frame_count = 16'hFFFF;
      if (k == 416) begin
        chk("frame_count_wrap", int'(z_fc), 0);
        chk("frame_start_wrap", int'(z_fs), 1);
      end
`endif
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    chk("hs_low_width", hs_low, 96);
    chk("hs_first_low_hc", hs_first, 658);
    chk("d0_hs_first_low", zhs_first, 10);
    chk("d0_hs_width", zhs_low, 3);
    chk("d3_hs_first_low", ths_first, 13);
    chk("d3_hs_width", ths_low, 3);
    chk("d0_vs_first_low", zvs_first, 128);
    chk("d0_vs_width", zvs_low, 32);
    chk("d0_vs_contiguous", zvs_last - zvs_first + 1, 32);
    chk("d3_vs_first_low", tvs_first, 131);
    chk("d3_vs_width", tvs_low, 32);
    chk("d3_vs_contiguous", tvs_last - tvs_first + 1, 32);
    chk("blank_in_vblank", blank_bad, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_start_pulses", fs_pulses, 3);
`endif

    // Mid-line reset: full DUT at (300,2), reduced DUTs mid-frame.
    for (int k = 1701; k <= 1900; k++) step();
    chk("pre_reset_x", int'(d_x), 300);
    chk("pre_reset_y", int'(d_y), 2);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_DrawX", int'(d_x), 0);
    chk("rst_DrawY", int'(d_y), 0);
    chk("rst_blank", int'(d_blank), 1);
    chk("rst_hs", int'(d_hs), 1);
    chk("rst_vs", int'(d_vs), 1);
    chk("rst_small_xy", int'(z_x) + int'(z_y) + int'(t_x) + int'(t_y), 0);
    chk("rst_small_sync", int'(z_hs) + int'(z_vs) + int'(t_hs) + int'(t_vs), 4);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_frame_count", int'(z_fc) + int'(t_fc), 0);
`endif
    step();
    chk("post_rst_DrawX", int'(d_x), 1);
    chk("post_rst_DrawY", int'(d_y), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the 640x480 @ 60 Hz display path, running on the 25 MHz `vga_clk`. It produces `DrawX`/`DrawY` and the active-video `blank` flag that drive the tile/sprite mappers. It also produces `hs`/`vs` to the VGA connector, delayed so they stay aligned with the mappers' registered RGB output. It is the stage directly upstream of every `*_mapper` block.

## Interface

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_DELAY`, 2, pipeline stages on `hs`/`vs`; matches mapper latency of ROM read + output register

Ports:
- `vga_clk` input 1: pixel clock
- `reset` input 1: synchronous, active-high reset
- `DrawX` output 10: current pixel column (horizontal counter)
- `DrawY` output 10: current line (vertical counter)
- `blank` output 1: 1 = active video, 0 = blanking; same polarity the mappers gate RGB with
- `hs` output 1: horizontal sync, active low, delayed `SYNC_DELAY` cycles
- `vs` output 1: vertical sync, active low, delayed `SYNC_DELAY` cycles
- `frame_start` output 1: present only with `VGA_FRAME_CNT_EN`
- `frame_count` output 16: present only with `VGA_FRAME_CNT_EN`

## Operation

Totals:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = 525.

Counters:
- `hc`: 10-bit register, increments every `vga_clk`. At H_TOTAL-1 (799) it wraps to 0.
- `vc`: 10-bit register, increments only on the cycle `hc` wraps. At V_TOTAL-1 (524) it wraps to 0. At (799,524) both wrap together to (0,0).

Outputs derived from the counters:
- `DrawX` = `hc` and `DrawY` = `vc`, driven straight from the registers with no extra delay.
- `blank` = (`hc` < 640) && (`vc` < 480), combinational from the counter registers.
- `hs_raw` = 0 when 656 ≤ `hc` ≤ 751, else 1.
- `vs_raw` = 0 when 490 ≤ `vc` ≤ 491, else 1.
- `hs_raw`/`vs_raw` each pass through a `SYNC_DELAY`-deep shift register.
- With `SYNC_DELAY` = 0, `hs`/`vs` are combinational from the counters.

Reset (synchronous; overrides counting):
- `hc` = 0, `vc` = 0.
- All sync shift-register stages load 1.
- On the cycle after reset is sampled: `DrawX` = 0, `DrawY` = 0, `blank` = 1, `hs` = 1, `vs` = 1.
- Reset asserted mid-line or mid-frame abandons the frame. The first post-reset cycle is pixel (0,0) of a fresh frame.

Arithmetic:
- All comparisons are unsigned, 10-bit.
- The parameter sum must fit in 10 bits; parameters violating this are unsupported.

## Timing

- Line = 800 cycles; frame = 420 000 cycles.
- `DrawX`/`DrawY`/`blank` refer to the current cycle (latency 0).
- A downstream mapper presents RGB for pixel (x,y) exactly 2 cycles later. With `SYNC_DELAY` = 2, `hs`/`vs` edges land on the same cycle as that RGB.
- `hs` first goes low `SYNC_DELAY` cycles after `hc` reaches 656, and stays low exactly 96 cycles per line.
- `vs` goes low for exactly 2 full lines (1600 cycles) per frame. It transitions `SYNC_DELAY` cycles after `hc` wraps into line 490, and again into line 492.
- `blank` falls on the cycle `hc` = 640 and rises on `hc` = 0 of lines 0–479. It stays 0 for the whole of lines 480–524.

## Configuration

`VGA_FRAME_CNT_EN`:
- Defined:
  - `frame_start` = 1 for exactly the one cycle where `hc` = 0 and `vc` = 0, including the first cycle after reset.
  - `frame_count` is a 16-bit register. It is 0 after reset and increments by 1 on the (799,524)→(0,0) wrap, so it is valid on the same cycle `frame_start` is high.
  - `frame_count` wraps 65535→0 silently.
  - Game logic uses these for animation stepping.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Test plan

- Reset: hold `reset` 3 cycles mid-frame at (300,200), release → next cycle `DrawX` = 0, `DrawY` = 0, `blank` = 1, `hs` = 1, `vs` = 1; `frame_count` = 0 if enabled.
- Horizontal sweep: run one line from reset.
  - `blank` is 1 for `hc` 0–639 and falls at `hc` = 640.
  - `hs` low for exactly 96 cycles, starting at `hc` = 658 with `SYNC_DELAY` = 2.
  - `DrawX` wraps 799→0 and `DrawY` steps 0→1 on the same cycle.
- Vertical sweep: run one full frame.
  - `blank` is never 1 for `vc` ≥ 480.
  - `vs` low for exactly 1600 consecutive cycles, starting 2 cycles after (0,490).
  - Counters return to (0,0) after 420 000 cycles.
- Delay sweep: rebuild with `SYNC_DELAY` = 0 and 3 → `hs` falling edge at `hc` = 656 and `hc` = 659 respectively; pulse widths unchanged.
- Frame counter (`VGA_FRAME_CNT_EN`): run 3 frames → `frame_start` pulses at cycles 0, 420 000 and 840 000, each 1 cycle wide; `frame_count` reads 0, 1, 2 on those cycles.
- Frame counter wrap: force `frame_count` to 65535 via backdoor, cross one frame boundary → reads 0, `frame_start` pulses.
